ysyx_220053_wb_arbiter: RTL

- Write-back stage sitting directly upstream of the NPC register file's single write port (wen/waddr/wdata).
- Merges single-cycle ALU results with long-latency LSU results. LSU results are buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on RAW hazards against outstanding loads.
- Drives a registered write to the register file each cycle.

---
 rtl/ysyx_220053_wb_pkg.sv | 17 +
 rtl/ysyx_220053_wb_fifo.sv | 76 +++++++
 rtl/ysyx_220053_wb_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ysyx_220053_wb_pkg.sv
// Shared types and default sizing for the write-back arbiter slice.
package ysyx_220053_wb_pkg;

  localparam int unsigned WB_ADDR_W       = 5;
  localparam int unsigned WB_DATA_W       = 64;
  localparam int unsigned WB_BUF_DEPTH    = 2;
  localparam int unsigned WB_STARVE_LIMIT = 4;

  typedef logic [WB_ADDR_W-1:0] reg_idx_t;
  typedef logic [WB_DATA_W-1:0] xlen_t;

  typedef struct packed {
    reg_idx_t rd;
    xlen_t    data;
  } wb_entry_t;

endpackage

// File: rtl/ysyx_220053_wb_fifo.sv
// Synchronous FIFO of write-back entries with per-entry destination match
// vectors, so the arbiter can report sources still waiting in the buffer.
module ysyx_220053_wb_fifo
  import ysyx_220053_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wb_entry_t        entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             full_o,
  output logic             empty_o,
  input  reg_idx_t         q1_rd_i,
  input  reg_idx_t         q2_rd_i,
  output logic [DEPTH-1:0] q1_match_o,
  output logic [DEPTH-1:0] q2_match_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] off;
  logic             live;
  logic             do_push, do_pop;
  wb_entry_t        mem_q [DEPTH];

  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q[PTR_W-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_comb begin
    wr_d = wr_q + CNT_W'(do_push);
    rd_d = rd_q + CNT_W'(do_pop);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PTR_W-1:0]] <= entry_i;
  end

  // Match each live entry's destination against the two queried indices.
  always_comb begin
    count      = wr_q - rd_q;
    off        = '0;
    live       = 1'b0;
    q1_match_o = '0;
    q2_match_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off           = PTR_W'(i) - rd_q[PTR_W-1:0];
      live          = CNT_W'(off) < count;
      q1_match_o[i] = live && (mem_q[i].rd == q1_rd_i);
      q2_match_o[i] = live && (mem_q[i].rd == q2_rd_i);
    end
  end

endmodule

// File: rtl/ysyx_220053_wb_arbiter.sv
// Write-back arbiter: merges ALU and buffered LSU results onto the single
// register-file write port and tracks outstanding long-latency destinations.
// Optional build macro YSYX_220053_WB_FWD_EN adds rsN_fwd_valid/rsN_fwd_data
// outputs that expose the registered write before the regfile commits it.
module ysyx_220053_wb_arbiter
  import ysyx_220053_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = WB_ADDR_W,
  parameter int unsigned DATA_WIDTH    = WB_DATA_W,
  parameter int unsigned LSU_BUF_DEPTH = WB_BUF_DEPTH,
  parameter int unsigned STARVE_LIMIT  = WB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  sb_set,
  input  logic [ADDR_WIDTH-1:0] sb_rd,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef YSYX_220053_WB_FWD_EN
  ,
  output logic                  rs1_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic                  rs2_fwd_valid,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data
`endif
);

  localparam int unsigned NREG  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                     rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0]    rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0]    rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]          pend_q, pend_d;
  logic [CNT_W-1:0]         starve_q, starve_d;

  logic                     fifo_full, fifo_empty;
  wb_entry_t                lsu_entry, head;
  logic [LSU_BUF_DEPTH-1:0] q1_match, q2_match;
  logic                     alu_fire, lsu_fire, pop;

  assign lsu_entry = '{rd: reg_idx_t'(lsu_rd), data: xlen_t'(lsu_data)};

  // Starved head forces one ALU back-off cycle; full FIFO refuses pushes.
  assign alu_ready = rst & (starve_q != CNT_W'(STARVE_LIMIT));
  assign lsu_ready = rst & ~fifo_full;
  assign alu_fire  = alu_valid & alu_ready;
  assign lsu_fire  = lsu_valid & lsu_ready;
  assign pop       = ~alu_fire & ~fifo_empty;

  ysyx_220053_wb_fifo #(
    .DEPTH (LSU_BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push_i     (lsu_fire),
    .entry_i    (lsu_entry),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .q1_rd_i    (reg_idx_t'(rs1_addr)),
    .q2_rd_i    (reg_idx_t'(rs2_addr)),
    .q1_match_o (q1_match),
    .q2_match_o (q2_match)
  );

  // Select this cycle's writer, update scoreboard and starvation count.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pend_d     = pend_q;
    starve_d   = '0;
    if (alu_fire) begin
      rf_wen_d   = (alu_rd != '0);
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
      if (!fifo_empty) starve_d = starve_q + CNT_W'(1);
    end else if (pop) begin
      rf_wen_d   = (head.rd != '0);
      rf_waddr_d = ADDR_WIDTH'(head.rd);
      rf_wdata_d = DATA_WIDTH'(head.data);
      pend_d[ADDR_WIDTH'(head.rd)] = 1'b0;
    end
    // A new issue to the same destination outranks the retiring load.
    if (sb_set && (sb_rd != '0)) pend_d[sb_rd] = 1'b1;
  end

  // Registered write port, scoreboard and starvation state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pend_q     <= '0;
      starve_q   <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pend_q     <= pend_d;
      starve_q   <= starve_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // A source is busy while its load is outstanding or still buffered.
  assign rs1_busy = pend_q[rs1_addr] | ((rs1_addr != '0) & (|q1_match));
  assign rs2_busy = pend_q[rs2_addr] | ((rs2_addr != '0) & (|q2_match));

`ifdef YSYX_220053_WB_FWD_EN
  // Bypass the registered write during the cycle before regfile commit.
  assign rs1_fwd_valid = rf_wen_q & (rf_waddr_q == rs1_addr) & (rs1_addr != '0);
  assign rs2_fwd_valid = rf_wen_q & (rf_waddr_q == rs2_addr) & (rs2_addr != '0);
  assign rs1_fwd_data  = rf_wdata_q;
  assign rs2_fwd_data  = rf_wdata_q;
`endif

endmodule
